// File: rtl/addr_decoder_cfg_sequencer.sv
// Expands one window descriptor per handshake into byte-wide addr_decoder
// config writes, round-robin arbitrating between a loader (req0) and host (req1).
module addr_decoder_cfg_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_WIN   = 16,
  parameter int unsigned NUM_SLOTS = 5
) (
  input  logic                       cfg_clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [$clog2(NUM_WIN)-1:0] req0_win,
  input  logic [ADDR_W-1:0]          req0_base,
  input  logic [ADDR_W-1:0]          req0_mask,
  input  logic [2:0]                 req0_slot,
  input  logic [7:0]                 req0_op,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [$clog2(NUM_WIN)-1:0] req1_win,
  input  logic [ADDR_W-1:0]          req1_base,
  input  logic [ADDR_W-1:0]          req1_mask,
  input  logic [2:0]                 req1_slot,
  input  logic [7:0]                 req1_op,
  output logic                       cfg_we,
  output logic [7:0]                 cfg_addr,
  output logic [7:0]                 cfg_wdata,
  output logic                       busy,
  output logic                       grant_id,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned CFG_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned WIN_W     = $clog2(NUM_WIN);
  localparam int unsigned PAD_W     = CFG_BYTES * 8;
  localparam int unsigned NWR       = 2 * CFG_BYTES + 2;
  localparam int unsigned K_W       = $clog2(NWR + 1);
  localparam int unsigned MASK_OFF  = NUM_WIN * CFG_BYTES;
  localparam int unsigned SLOT_OFF  = 2 * NUM_WIN * CFG_BYTES;
  localparam int unsigned OP_OFF    = SLOT_OFF + NUM_WIN;

  typedef enum logic [1:0] {IDLE, WRITE, REJECT} state_e;

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [PAD_W-1:0]   base_q, base_d;
  logic [PAD_W-1:0]   mask_q, mask_d;
  logic [2:0]         slot_q, slot_d;
  logic [7:0]         op_q, op_d;
  logic               we_q, we_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic               gid_q, gid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               acc, gid;
  logic [WIN_W-1:0]   a_win;
  logic [PAD_W-1:0]   a_base, a_mask;
  logic [2:0]         a_slot;
  logic [7:0]         a_op;
  logic [15:0]        beat0, beatk;

  // Write k of a burst: {cfg_addr, cfg_wdata}.
  function automatic logic [15:0] beat(input logic [K_W-1:0] k, input logic [WIN_W-1:0] w,
                                       input logic [PAD_W-1:0] b, input logic [PAD_W-1:0] m,
                                       input logic [2:0] s, input logic [7:0] o);
    int unsigned ki, wi;
    logic [7:0]  a, d;
    ki = 32'(k);
    wi = 32'(w);
    if (ki < CFG_BYTES) begin
      a = 8'(wi * CFG_BYTES + ki);
      d = b[8*ki +: 8];
    end else if (ki < 2 * CFG_BYTES) begin
      a = 8'(MASK_OFF + wi * CFG_BYTES + (ki - CFG_BYTES));
      d = m[8*(ki - CFG_BYTES) +: 8];
    end else if (ki == 2 * CFG_BYTES) begin
      a = 8'(SLOT_OFF + wi);
      d = {5'b0, s};
    end else begin
      a = 8'(OP_OFF + wi);
      d = o;
    end
    return {a, d};
  endfunction

  // With both requesting, the one not served last wins.
  always_comb begin
    gid    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    acc    = (state_q == IDLE) && (req0_valid || req1_valid);
    a_win  = gid ? req1_win  : req0_win;
    a_base = gid ? PAD_W'(req1_base) : PAD_W'(req0_base);
    a_mask = gid ? PAD_W'(req1_mask) : PAD_W'(req0_mask);
    a_slot = gid ? req1_slot : req0_slot;
    a_op   = gid ? req1_op   : req0_op;
    beat0  = beat(K_W'(0), a_win, a_base, a_mask, a_slot, a_op);
    beatk  = beat(k_q, win_q, base_q, mask_q, slot_q, op_q);
  end

  assign req0_ready = acc && !gid;
  assign req1_ready = acc && gid;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    win_d   = win_q;
    base_d  = base_q;
    mask_d  = mask_q;
    slot_d  = slot_q;
    op_d    = op_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = 1'b0;
    gid_d   = gid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          win_d  = a_win;
          base_d = a_base;
          mask_d = a_mask;
          slot_d = a_slot;
          op_d   = a_op;
          gid_d  = gid;
          last_d = gid;
          if (32'(a_slot) >= NUM_SLOTS) begin
            state_d = REJECT;
          end else begin
            // Byte 0 is issued on the acceptance edge so writes are back-to-back.
            state_d           = WRITE;
            we_d              = 1'b1;
            busy_d            = 1'b1;
            {addr_d, wdata_d} = beat0;
            k_d               = K_W'(1);
          end
        end
      end
      WRITE: begin
        if (k_q == K_W'(NWR)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          we_d              = 1'b1;
          busy_d            = 1'b1;
          {addr_d, wdata_d} = beatk;
          k_d               = k_q + K_W'(1);
        end
      end
      REJECT: begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cfg_clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      win_q   <= '0;
      base_q  <= '0;
      mask_q  <= '0;
      slot_q  <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      win_q   <= win_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      slot_q  <= slot_d;
      op_q    <= op_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cfg_we    = we_q;
  assign cfg_addr  = addr_q;
  assign cfg_wdata = wdata_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_addr_decoder_cfg_sequencer.sv
// Bench for addr_decoder_cfg_sequencer: directed and random descriptors checked
// cycle by cycle against a timeline model of the config-write protocol.
module tb_addr_decoder_cfg_sequencer;

  logic        cfg_clk = 1'b0;
  logic        rst_n   = 1'b1;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_win, req1_win;
  logic [31:0] req0_base, req0_mask, req1_base, req1_mask;
  logic [2:0]  req0_slot, req1_slot;
  logic [7:0]  req0_op, req1_op;
  logic        cfg_we, busy, grant_id, done, err;
  logic [7:0]  cfg_addr, cfg_wdata;

  always #5 cfg_clk = ~cfg_clk;

  addr_decoder_cfg_sequencer #(.ADDR_W(32), .NUM_WIN(16), .NUM_SLOTS(5)) dut (
    .cfg_clk(cfg_clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_win(req0_win),
    .req0_base(req0_base), .req0_mask(req0_mask), .req0_slot(req0_slot), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_win(req1_win),
    .req1_base(req1_base), .req1_mask(req1_mask), .req1_slot(req1_slot), .req1_op(req1_op),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .grant_id(grant_id), .done(done), .err(err)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle expectations held in a circular timeline.
  int unsigned cyc = 0;
  always @(posedge cfg_clk) cyc++;

  bit          ew[64], edn[64], eer[64], ebz[64];
  logic [7:0]  ea[64], ed[64];
  int unsigned free_at = 0;
  int unsigned gid_at  = 0;
  bit          m_last = 1'b1, m_gid = 1'b0, m_gid_nx = 1'b0, gid_pend = 1'b0;

  function automatic void schedule(input bit id);
    logic [3:0]  w;
    logic [31:0] b, m;
    logic [2:0]  s;
    logic [7:0]  o;
    int unsigned t;
    w = id ? req1_win : req0_win;
    b = id ? req1_base : req0_base;
    m = id ? req1_mask : req0_mask;
    s = id ? req1_slot : req0_slot;
    o = id ? req1_op : req0_op;
    m_last   = id;
    m_gid_nx = id;
    gid_pend = 1'b1;
    gid_at   = cyc + 1;
    if (s >= 3'd5) begin
      eer[(cyc + 2) % 64] = 1'b1;
      free_at = cyc + 2;
    end else begin
      for (int j = 0; j < 10; j++) begin
        t = (cyc + 1 + j) % 64;
        ew[t]  = 1'b1;
        ebz[t] = 1'b1;
        if (j < 4) begin
          ea[t] = 8'(w * 4 + j);
          ed[t] = 8'(b >> (8 * j));
        end else if (j < 8) begin
          ea[t] = 8'(64 + w * 4 + (j - 4));
          ed[t] = 8'(m >> (8 * (j - 4)));
        end else if (j == 8) begin
          ea[t] = 8'(128 + w);
          ed[t] = 8'(s);
        end else begin
          ea[t] = 8'(144 + w);
          ed[t] = o;
        end
      end
      edn[(cyc + 11) % 64] = 1'b1;
      free_at = cyc + 11;
    end
  endfunction

  always @(negedge cfg_clk) begin : monitor
    int unsigned s;
    bit e0, e1;
    s = cyc % 64;
    if (rst_n) begin
      for (int i = 0; i < 64; i++) begin
        ew[i] = 0; edn[i] = 0; eer[i] = 0; ebz[i] = 0;
      end
      m_last = 1'b1; m_gid = 1'b0; gid_pend = 1'b0; free_at = cyc;
      check("rst_we",    32'(cfg_we),    0);
      check("rst_busy",  32'(busy),      0);
      check("rst_done",  32'(done),      0);
      check("rst_err",   32'(err),       0);
      check("rst_gid",   32'(grant_id),  0);
      check("rst_addr",  32'(cfg_addr),  0);
      check("rst_wdata", 32'(cfg_wdata), 0);
    end else begin
      if (gid_pend && cyc >= gid_at) begin
        m_gid = m_gid_nx;
        gid_pend = 1'b0;
      end
      check("cfg_we", 32'(cfg_we), 32'(ew[s]));
      if (ew[s]) begin
        check("cfg_addr",  32'(cfg_addr),  32'(ea[s]));
        check("cfg_wdata", 32'(cfg_wdata), 32'(ed[s]));
      end
      check("done",     32'(done),     32'(edn[s]));
      check("err",      32'(err),      32'(eer[s]));
      check("busy",     32'(busy),     32'(ebz[s]));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      ew[s] = 0; edn[s] = 0; eer[s] = 0; ebz[s] = 0;
      e0 = 1'b0;
      e1 = 1'b0;
      if (cyc >= free_at) begin
        e0 = req0_valid && (!req1_valid || m_last);
        e1 = req1_valid && (!req0_valid || !m_last);
      end
      check("req0_ready", 32'(req0_ready), 32'(e0));
      check("req1_ready", 32'(req1_ready), 32'(e1));
      if (e0 || e1) schedule(e1);
    end
  end

  task automatic drive(input bit id, input bit v, input logic [3:0] w, input logic [31:0] b,
                       input logic [31:0] m, input logic [2:0] s, input logic [7:0] o);
    if (id) begin
      req1_win = w; req1_base = b; req1_mask = m; req1_slot = s; req1_op = o; req1_valid = v;
    end else begin
      req0_win = w; req0_base = b; req0_mask = m; req0_slot = s; req0_op = o; req0_valid = v;
    end
  endtask

  task automatic scramble(input bit id, input bit v);
    drive(id, v, 4'($urandom), $urandom, $urandom, 3'($urandom_range(0, 7)), 8'($urandom));
  endtask

  // Offer a descriptor until accepted, then scramble the inputs with valid low.
  task automatic send(input bit id, input logic [3:0] w, input logic [31:0] b,
                      input logic [31:0] m, input logic [2:0] s, input logic [7:0] o);
    bit hs = 1'b0;
    drive(id, 1'b1, w, b, m, s, o);
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge cfg_clk);
      hs = id ? req1_ready : req0_ready;
    end
    check("handshake", 32'(hs), 1);
    @(posedge cfg_clk);
    #1;
    scramble(id, 1'b0);
  endtask

  task automatic send_rand(input bit id);
    send(id, 4'($urandom), $urandom, $urandom, 3'($urandom_range(0, 4)), 8'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge cfg_clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge cfg_clk); #2 rst_n = 1'b1;
    @(posedge cfg_clk); #2 rst_n = 1'b0;
  endtask

  initial begin
    scramble(0, 1'b0);
    scramble(1, 1'b0);
    repeat (3) @(posedge cfg_clk);
    #2 rst_n = 1'b0;
    idle(2);

    send(0, 4'd0, 32'h1000_0000, 32'hFFFF_FF00, 3'd0, 8'hFF);
    idle(12);
    send(1, 4'd15, 32'hF000_0300, 32'hFFFF_F000, 3'd4, 8'hFF);
    idle(12);

    pulse_reset();
    fork
      begin
        for (int i = 0; i < 3; i++) send_rand(0);
      end
      begin
        for (int i = 0; i < 3; i++) send_rand(1);
      end
    join
    idle(12);

    send(0, 4'd3, 32'h1234_5678, 32'h0000_FFFF, 3'd5, 8'h01);
    send(1, 4'd7, 32'hCAFE_0000, 32'hFFFF_0000, 3'd2, 8'h00);
    idle(12);

    send_rand(0);
    repeat (4) @(posedge cfg_clk);
    #2 rst_n = 1'b1;
    #1;
    check("async_we",   32'(cfg_we), 0);
    check("async_busy", 32'(busy),   0);
    @(posedge cfg_clk); #2 rst_n = 1'b0;
    send_rand(1);
    idle(12);

    for (int c = 0; c < 1500; c++) begin
      scramble(0, $urandom_range(0, 3) != 0);
      scramble(1, $urandom_range(0, 3) != 0);
      idle(1);
    end
    scramble(0, 1'b0);
    scramble(1, 1'b0);
    idle(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_decoder_cfg_sequencer.md
Name: addr_decoder_cfg_sequencer

Overview:
- Writes window descriptors into the addr_decoder configuration port (cfg_we/cfg_addr/cfg_wdata) on behalf of two requesters: req0 for the boot/MCU loader and req1 for the host.
- Takes one complete window descriptor (index, base, mask, slot, op) per handshake and expands it into the byte-wide register writes the decoder needs.
- Round-robin arbitration between the requesters; each descriptor's burst runs to completion before the other requester is served.

Parameters:
- ADDR_W, 32, decoder address width; CFG_BYTES = (ADDR_W+7)/8.
- NUM_WIN, 16, number of decoder windows; window-index width WIN_W = $clog2(NUM_WIN).
- NUM_SLOTS, 5, number of valid slot targets.

Ports:
- cfg_clk  in  1  configuration clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-high (rst_n=1 resets).
- reqN_valid  in  1  (N=0,1) descriptor offered.
- reqN_ready  out  1  descriptor accepted this cycle.
- reqN_win  in  WIN_W  target window index.
- reqN_base  in  ADDR_W  window base.
- reqN_mask  in  ADDR_W  window mask.
- reqN_slot  in  3  target slot.
- reqN_op  in  8  op code (FF = read/write, 00 = write-only, 01 = read-only); passed through unchecked.
- cfg_we  out  1  decoder config write strobe.
- cfg_addr  out  8  decoder config register address.
- cfg_wdata  out  8  decoder config write data.
- busy  out  1  a burst is in progress.
- grant_id  out  1  requester owning the current or most recent transaction.
- done  out  1  one-cycle pulse: burst complete.
- err  out  1  one-cycle pulse: descriptor rejected.

Behaviour:
- Reset values: cfg_we=0, cfg_addr=0, cfg_wdata=0, busy=0, grant_id=0, done=0, err=0, internal last_grant=1, state=IDLE. Reset is asynchronous and takes effect mid-burst; the partially written window is left as-is.
- Config map offsets:
  - BASE_OFF = 0.
  - MASK_OFF = NUM_WIN*CFG_BYTES (64 at defaults).
  - SLOT_OFF = 2*NUM_WIN*CFG_BYTES (128).
  - OP_OFF = SLOT_OFF + NUM_WIN (144).
- Addresses are truncated to 8 bits.
- Address for window w and byte b:
  - base: BASE_OFF + w*CFG_BYTES + b.
  - mask: MASK_OFF + w*CFG_BYTES + b.
  - slot: SLOT_OFF + w.
  - op: OP_OFF + w.
- Bytes go out little-endian, b=0 first: data[8*b +: 8].
- Arbitration, IDLE only:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready is combinational = (state==IDLE) && grant to N. At most one ready per cycle; never asserted outside IDLE.
- Acceptance is the cycle where valid && ready. On that edge:
  - The descriptor is registered.
  - last_grant and grant_id are set to N.
  - The state moves to WRITE (slot legal) or REJECT (slot illegal).
  - Later input changes do not affect the burst.
- Slot check: reqN_slot >= NUM_SLOTS is illegal.
- REJECT: one cycle with no cfg_we, then IDLE. err=1 in the following IDLE cycle.
- WRITE:
  - Byte counter k runs 0 .. 2*CFG_BYTES+1 (10 writes at defaults).
  - Order: base bytes 0..3, then mask bytes 0..3, then slot {5'b0,slot}, then op.
  - One write per cycle; cfg_we=1 for the whole burst, back-to-back; cfg_addr and cfg_wdata are registered and valid in the same cycle as cfg_we.
  - busy=1 from the acceptance edge through the last write cycle.
  - After k = last: cfg_we=0 and state returns to IDLE.
- Completion: done=1 for exactly the first IDLE cycle after the last write. A new descriptor may be accepted in that same cycle.
- Latency: accept at edge T, then writes in cycles T+1..T+10, then done at T+11.
- Outside WRITE: cfg_we=0; cfg_addr and cfg_wdata hold their last values.
- Simultaneous events: a requester dropping valid without handshake is legal and nothing is captured.

Test Plan:
- Single req0, win=0, base=1000_0000, mask=FFFF_FF00, slot=0, op=FF → cfg_we high 10 consecutive cycles:
  - addr 0..3 with data 00,00,00,10;
  - addr 64..67 with data 00,FF,FF,FF;
  - addr 128 with data 00; addr 144 with data FF;
  - done one cycle later; busy low after.
- req1 win=15, base=F000_0300, slot=4, op=FF → addrs 60..63, 124..127, 143, 159; data 00,03,00,F0 for the base bytes.
- Both valid from IDLE right after reset → req0 granted first; req1 granted on the done cycle; then with both held valid, grants alternate 0,1,0,1 and each burst is contiguous with no interleaved writes.
- req0 slot=5 → ready handshake completes, err pulse, zero cfg_we cycles, done stays 0; the next req1 is served normally.
- Assert rst_n at burst byte 4 → cfg_we=0 and busy=0 immediately (asynchronous); after release a fresh descriptor runs the full 10-write burst.
- Descriptor inputs changed after acceptance → written bytes match the values captured at acceptance.
